// File: rtl/mode_ctrl_scan.sv
// Mode controller: debounced buttons, OFF/MENU/ACTIVE FSM and an 8-digit multiplexed display.
// Optional idle auto-off is enabled with `define MODE_CTRL_AUTO_OFF_EN.
module mode_ctrl_scan #(
  parameter int unsigned NUM_MODES         = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 300000000,
  parameter int unsigned SCAN_DIV          = 100000,
  parameter int unsigned IDLE_CYCLES       = 32'd3000000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     power_button,
  input  logic                     confirm,
  input  logic                     select,
  input  logic                     exit,
  input  logic [NUM_MODES-1:0]     mode_busy,
  input  logic [NUM_MODES*64-1:0]  mode_seg,
  input  logic [NUM_MODES*8-1:0]   mode_led,
  output logic [NUM_MODES-1:0]     mode_sel,
  output logic                     mode_entered,
  output logic                     power_on,
  output logic [7:0]               Seg1,
  output logic [7:0]               Seg2,
  output logic [7:0]               anode,
  output logic [7:0]               led
);

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned BTN_PWR = 0;
  localparam int unsigned BTN_CNF = 1;
  localparam int unsigned BTN_SEL = 2;
  localparam int unsigned BTN_EXT = 3;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int unsigned SD_W    = $clog2(SCAN_DIV + 1);

  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_MENU = 2'd1, ST_ACTIVE = 2'd2} state_t;

  function automatic logic [7:0] glyph(input int n);
    case (n)
      1:       glyph = 8'h60;
      2:       glyph = 8'hDA;
      3:       glyph = 8'hF2;
      4:       glyph = 8'h66;
      5:       glyph = 8'hB6;
      6:       glyph = 8'hBE;
      7:       glyph = 8'hE0;
      8:       glyph = 8'hFE;
      9:       glyph = 8'hF6;
      default: glyph = 8'h00;
    endcase
  endfunction

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync1_q, sync2_q, level_q, level_d, press_q, press_d;
  logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
  logic [LP_W-1:0]    hold_q, hold_d;
  logic               long_hit_c;
  logic               auto_off_c;
  logic               sel_busy_c;
  state_t             state_q, state_d;
  logic [NUM_MODES-1:0] mode_sel_q, mode_sel_d;
  logic               power_on_q, mode_entered_q;
  logic [SD_W-1:0]    div_q, div_d;
  logic [2:0]         digit_q, digit_d;
  logic [63:0]        frame_c;
  logic [7:0]         cur_glyph_c;
  logic [7:0]         seg1_q, seg1_d, seg2_q, seg2_d, anode_q, anode_d, led_q, led_d;

  assign btn_raw = {exit, select, confirm, power_button};

  // Debounce: a differing synchronised level must persist DEBOUNCE_CYCLES samples to be accepted.
  always_comb begin
    level_d = level_q;
    for (int b = 0; b < int'(NUM_BTN); b++) begin
      db_cnt_d[b] = '0;
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) level_d[b] = sync2_q[b];
        else db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  // Long-press timer saturates so the forced-off condition holds until release.
  always_comb begin
    hold_d = '0;
    if (level_q[BTN_PWR]) begin
      hold_d = (hold_q == LP_W'(LONG_PRESS_CYCLES)) ? hold_q : hold_q + LP_W'(1);
    end
    long_hit_c = (hold_q == LP_W'(LONG_PRESS_CYCLES));
  end

  assign sel_busy_c = |(mode_busy & mode_sel_q);

`ifdef MODE_CTRL_AUTO_OFF_EN
  localparam int unsigned ID_W = $clog2(IDLE_CYCLES + 1);
  logic [ID_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = '0;
    if (!(|press_q) && !(|mode_busy) && (state_q != ST_OFF)) begin
      idle_d = (idle_q == ID_W'(IDLE_CYCLES)) ? idle_q : idle_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign auto_off_c = (idle_q == ID_W'(IDLE_CYCLES));
`else
  assign auto_off_c = 1'b0;
`endif

  // Mode FSM; forced-off wins over every press.
  always_comb begin
    state_d    = state_q;
    mode_sel_d = mode_sel_q;
    case (state_q)
      ST_OFF: begin
        if (press_q[BTN_PWR]) begin
          state_d    = ST_MENU;
          mode_sel_d = NUM_MODES'(1);
        end
      end
      ST_MENU: begin
        if (long_hit_c || auto_off_c) begin
          state_d    = ST_OFF;
          mode_sel_d = NUM_MODES'(1);
        end else if (press_q[BTN_CNF]) begin
          state_d = ST_ACTIVE;
        end else if (press_q[BTN_SEL]) begin
          mode_sel_d = {mode_sel_q[NUM_MODES-2:0], mode_sel_q[NUM_MODES-1]};
        end
      end
      ST_ACTIVE: begin
        if (long_hit_c || auto_off_c) begin
          state_d    = ST_OFF;
          mode_sel_d = NUM_MODES'(1);
        end else if (press_q[BTN_EXT] && !sel_busy_c) begin
          state_d = ST_MENU;
        end
      end
      default: begin
        state_d    = ST_OFF;
        mode_sel_d = NUM_MODES'(1);
      end
    endcase
  end

  // Frame contents and LED pattern for the current state.
  always_comb begin
    frame_c = '0;
    led_d   = 8'h00;
    case (state_q)
      ST_MENU: begin
        led_d = 8'h01;
        for (int i = 0; i < int'(NUM_MODES); i++) begin
          if (mode_sel_q[i]) frame_c[7:0] = glyph(i + 1);
        end
      end
      ST_ACTIVE: begin
        for (int i = 0; i < int'(NUM_MODES); i++) begin
          if (mode_sel_q[i]) begin
            frame_c = mode_seg[i*64 +: 64];
            led_d   = mode_led[i*8 +: 8];
          end
        end
      end
      default: ;
    endcase
  end

  // Scanner: segments are looked up with the next digit so anode and segments move together.
  always_comb begin
    div_d   = div_q + SD_W'(1);
    digit_d = digit_q;
    if (div_q == SD_W'(SCAN_DIV - 1)) begin
      div_d   = '0;
      digit_d = digit_q + 3'd1;
    end
    cur_glyph_c = frame_c[{digit_d, 3'b000} +: 8];
    anode_d     = 8'h01 << digit_d;
    seg1_d      = digit_d[2] ? 8'h00 : cur_glyph_c;
    seg2_d      = digit_d[2] ? cur_glyph_c : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      level_q        <= '0;
      press_q        <= '0;
      for (int b = 0; b < int'(NUM_BTN); b++) db_cnt_q[b] <= '0;
      hold_q         <= '0;
      state_q        <= ST_OFF;
      mode_sel_q     <= NUM_MODES'(1);
      power_on_q     <= 1'b0;
      mode_entered_q <= 1'b0;
      div_q          <= '0;
      digit_q        <= 3'd0;
      seg1_q         <= 8'h00;
      seg2_q         <= 8'h00;
      anode_q        <= 8'h01;
      led_q          <= 8'h00;
    end else begin
      sync1_q        <= btn_raw;
      sync2_q        <= sync1_q;
      level_q        <= level_d;
      press_q        <= press_d;
      for (int b = 0; b < int'(NUM_BTN); b++) db_cnt_q[b] <= db_cnt_d[b];
      hold_q         <= hold_d;
      state_q        <= state_d;
      mode_sel_q     <= mode_sel_d;
      power_on_q     <= (state_d != ST_OFF);
      mode_entered_q <= (state_d == ST_ACTIVE);
      div_q          <= div_d;
      digit_q        <= digit_d;
      seg1_q         <= seg1_d;
      seg2_q         <= seg2_d;
      anode_q        <= anode_d;
      led_q          <= led_d;
    end
  end

  assign mode_sel     = mode_sel_q;
  assign power_on     = power_on_q;
  assign mode_entered = mode_entered_q;
  assign Seg1         = seg1_q;
  assign Seg2         = seg2_q;
  assign anode        = anode_q;
  assign led          = led_q;

endmodule

// File: tb/tb_mode_ctrl_scan.sv
// Scoreboard bench for mode_ctrl_scan with small debounce/long-press/scan/idle constants.
module tb_mode_ctrl_scan;

  localparam int unsigned NM = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              power_button = 1'b0;
  logic              confirm = 1'b0;
  logic              select = 1'b0;
  logic              exit = 1'b0;
  logic [NM-1:0]     mode_busy = '0;
  logic [NM*64-1:0]  mode_seg = '0;
  logic [NM*8-1:0]   mode_led = '0;
  logic [NM-1:0]     mode_sel;
  logic              mode_entered, power_on;
  logic [7:0]        Seg1, Seg2, anode, led;

  mode_ctrl_scan #(
    .NUM_MODES(NM), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(50),
    .SCAN_DIV(3), .IDLE_CYCLES(200)
  ) dut (
    .clk(clk), .reset(reset), .power_button(power_button), .confirm(confirm),
    .select(select), .exit(exit), .mode_busy(mode_busy), .mode_seg(mode_seg),
    .mode_led(mode_led), .mode_sel(mode_sel), .mode_entered(mode_entered),
    .power_on(power_on), .Seg1(Seg1), .Seg2(Seg2), .anode(anode), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [5:0] status();
    return {mode_entered, power_on, mode_sel};
  endfunction

  task automatic sb_push(input string n, input logic me, input logic po, input logic [3:0] sel);
    exp_t e;
    e.name = n;
    e.st   = {me, po, sel};
    sb.push_back(e);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: power_button = v;
      1: confirm      = v;
      2: select       = v;
      default: exit   = v;
    endcase
  endtask

  task automatic press_btn(input int b, input int hold);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_anode(input logic [7:0] val, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (anode === val) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (status() !== 6'b00_0001 || anode !== 8'h01 || Seg1 !== 8'h00 || Seg2 !== 8'h00 || led !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: status=%b anode=%h seg1=%h seg2=%h led=%h, required 000001/01/00/00/00",
               status(), anode, Seg1, Seg2, led);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_power_on();
    exp_t e;
    logic ok, bad;
    sb_push("power_on", 1'b0, 1'b1, 4'b0001);
    press_btn(0, 10);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st) begin
      errors++;
      $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
    end
    wait_anode(8'h01, ok);
    checks++;
    if (!ok || Seg1 !== 8'h60 || Seg2 !== 8'h00 || led !== 8'h01) begin
      errors++;
      $display("FAIL menu_digit0: ok=%b seg1=%h seg2=%h led=%h, required 1/60/00/01", ok, Seg1, Seg2, led);
    end
    bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (anode !== 8'h01 && (Seg1 !== 8'h00 || Seg2 !== 8'h00)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL menu_other_digits: got nonzero segments, required 00");
    end
  endtask

  task automatic test_select();
    exp_t e;
    logic [3:0] exp_sel = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      exp_sel = {exp_sel[2:0], exp_sel[3]};
      sb_push($sformatf("select_%0d", i), 1'b0, 1'b1, exp_sel);
      press_btn(2, 10);
      e = sb.pop_front();
      checks++;
      if (status() !== e.st) begin
        errors++;
        $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
      end
    end
    sb_push("select_glitch", 1'b0, 1'b1, 4'b0001);
    @(negedge clk);
    select = 1'b1;
    repeat (2) @(negedge clk);
    select = 1'b0;
    repeat (12) @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st) begin
      errors++;
      $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
    end
  endtask

  task automatic test_confirm_beats_select();
    exp_t e;
    sb_push("confirm_and_select", 1'b1, 1'b1, 4'b0001);
    @(negedge clk);
    confirm = 1'b1;
    select  = 1'b1;
    repeat (10) @(negedge clk);
    confirm = 1'b0;
    select  = 1'b0;
    repeat (10) @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st) begin
      errors++;
      $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
    end
    sb_push("exit_idle", 1'b0, 1'b1, 4'b0001);
    press_btn(3, 10);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st) begin
      errors++;
      $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
    end
  endtask

  task automatic test_active();
    exp_t e;
    logic ok;
    for (int m = 0; m < int'(NM); m++) begin
      for (int d = 0; d < 8; d++) mode_seg[m*64 + 8*d +: 8] = 8'hEE;
      mode_led[m*8 +: 8] = 8'h5A;
    end
    for (int d = 0; d < 8; d++) mode_seg[2*64 + 8*d +: 8] = 8'(8'h20 + d);
    mode_seg[2*64 +: 8]      = 8'h11;
    mode_seg[2*64 + 40 +: 8] = 8'hB6;
    mode_led[2*8 +: 8]       = 8'hA5;
    press_btn(2, 10);
    press_btn(2, 10);
    wait_anode(8'h01, ok);
    checks++;
    if (!ok || mode_sel !== 4'b0100 || Seg1 !== 8'hF2) begin
      errors++;
      $display("FAIL menu_glyph3: sel=%b seg1=%h, required 0100/F2", mode_sel, Seg1);
    end
    sb_push("confirm_enter", 1'b1, 1'b1, 4'b0100);
    press_btn(1, 10);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st) begin
      errors++;
      $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
    end
    wait_anode(8'h20, ok);
    checks++;
    if (!ok || Seg2 !== 8'hB6 || Seg1 !== 8'h00 || led !== 8'hA5) begin
      errors++;
      $display("FAIL active_digit5: ok=%b seg2=%h seg1=%h led=%h, required 1/B6/00/A5", ok, Seg2, Seg1, led);
    end
    wait_anode(8'h01, ok);
    checks++;
    if (!ok || Seg1 !== 8'h11 || Seg2 !== 8'h00) begin
      errors++;
      $display("FAIL active_digit0: ok=%b seg1=%h seg2=%h, required 1/11/00", ok, Seg1, Seg2);
    end
    sb_push("active_ignores_select_confirm", 1'b1, 1'b1, 4'b0100);
    press_btn(2, 10);
    press_btn(1, 10);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st) begin
      errors++;
      $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
    end
    mode_busy = 4'b0100;
    sb_push("exit_while_busy", 1'b1, 1'b1, 4'b0100);
    press_btn(3, 10);
    mode_busy = 4'b0000;
    repeat (10) @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st) begin
      errors++;
      $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
    end
    sb_push("exit_after_busy", 1'b0, 1'b1, 4'b0100);
    press_btn(3, 10);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st) begin
      errors++;
      $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
    end
  endtask

  task automatic test_long_press();
    exp_t e;
    logic bad;
    press_btn(1, 10);
    sb_push("long_press_off", 1'b0, 1'b0, 4'b0001);
    @(negedge clk);
    power_button = 1'b1;
    repeat (60) @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st || led !== 8'h00) begin
      errors++;
      $display("FAIL %s: status=%b led=%h required %b/00", e.name, status(), led, e.st);
    end
    bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (Seg1 !== 8'h00 || Seg2 !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL off_blank: got nonzero segments, required 00");
    end
    repeat (40) @(negedge clk);
    power_button = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (power_on !== 1'b0) begin
      errors++;
      $display("FAIL hold_then_release: power_on=%b required 0", power_on);
    end
    sb_push("repress_on", 1'b0, 1'b1, 4'b0001);
    press_btn(0, 10);
    e = sb.pop_front();
    checks++;
    if (status() !== e.st) begin
      errors++;
      $display("FAIL %s: status=%b required %b", e.name, status(), e.st);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic ok;
    wait_anode(8'h10, ok);
    reset = 1'b1;
    #1;
    checks++;
    if (!ok || anode !== 8'h01 || Seg1 !== 8'h00 || Seg2 !== 8'h00 || led !== 8'h00 || power_on !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: ok=%b anode=%h seg1=%h seg2=%h led=%h pwr=%b, required 1/01/00/00/00/0",
               ok, anode, Seg1, Seg2, led, power_on);
    end
    power_button = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (power_on !== 1'b0) begin
      errors++;
      $display("FAIL held_through_reset_early: power_on=%b required 0", power_on);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (power_on !== 1'b1 || mode_sel !== 4'b0001) begin
      errors++;
      $display("FAIL held_through_reset_late: power_on=%b sel=%b required 1/0001", power_on, mode_sel);
    end
    power_button = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_auto_off();
    logic exp_on;
`ifdef MODE_CTRL_AUTO_OFF_EN
    exp_on = 1'b0;
`else
    exp_on = 1'b1;
`endif
    repeat (250) @(negedge clk);
    checks++;
    if (power_on !== exp_on) begin
      errors++;
      $display("FAIL auto_off: power_on=%b required %b", power_on, exp_on);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_select();
    test_confirm_beats_select();
    test_active();
    test_long_press();
    test_reset_mid_scan();
    test_auto_off();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_ctrl_scan.md
MODE_CTRL_SCAN -- requirements
Module: mode_ctrl_scan

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4: number of selectable modes, range 2..9.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles a button needs to register.
REQ-003 SHALL have parameter LONG_PRESS_CYCLES, default 300000000: continuous power_button hold that forces power-off.
REQ-004 SHALL have parameter SCAN_DIV, default 100000: clk cycles per digit during scanning.
REQ-005 SHALL have parameter IDLE_CYCLES, default 3000000000: auto-off timeout (used only with the REQ-027 macro).
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have ports power_button, confirm, select, exit, each input, 1: raw asynchronous buttons, active-high.
REQ-009 SHALL have port mode_busy, input, NUM_MODES: bit i high means mode i is inside a sub-operation.
REQ-010 SHALL have port mode_seg, input, NUM_MODES*64: mode i digits 0..7 at bits [i*64+8*d +: 8].
REQ-011 SHALL have port mode_led, input, NUM_MODES*8: LED pattern of mode i.
REQ-012 SHALL have outputs mode_sel (NUM_MODES, one-hot), mode_entered (1), power_on (1), Seg1 (8, digits 0-3), Seg2 (8, digits 4-7), anode (8, one-hot active-high), led (8).

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser and then a debounce counter that accepts a new level only after DEBOUNCE_CYCLES equal samples; a 0->1 change of the accepted level SHALL produce a 1-cycle press pulse.
REQ-014 SHALL implement FSM states OFF, MENU, ACTIVE; power_on = (state != OFF); mode_entered = (state == ACTIVE).
REQ-015 OFF: a power press SHALL move to MENU with mode_sel = 1; all other buttons are ignored.
REQ-016 MENU: a select press SHALL rotate mode_sel left by one and wrap from bit NUM_MODES-1 to bit 0; a confirm press SHALL move to ACTIVE.
REQ-017 ACTIVE: an exit press SHALL return to MENU only if mode_busy[sel] = 0; an exit while busy SHALL be dropped, not queued; select and confirm SHALL be ignored.
REQ-018 In MENU or ACTIVE: power_button held at the debounced level for LONG_PRESS_CYCLES SHALL move to OFF. Power-on then requires release followed by a new press.
REQ-019 Simultaneous events: long-press off beats everything; in MENU, confirm beats select and mode_sel is unchanged.
REQ-020 Each state change SHALL take effect on the clock edge after the press pulse.
REQ-021 Display frame:
  - OFF: all 8 digits 0x00.
  - MENU: digit 0 holds the glyph of (index+1), digits 1-7 are 0x00.
  - ACTIVE: digits taken from mode_seg of the selected mode.
REQ-022 Glyphs for 1..9 SHALL be 60,DA,F2,66,B6,BE,E0,FE,F6 (hex).
REQ-023 Scanner:
  - digit counter 0..7 advances every SCAN_DIV cycles and wraps 7->0.
  - anode = 1<<digit.
  - Seg1 = frame[digit] when digit<4, else 0x00; Seg2 = frame[digit] when digit>=4, else 0x00.
  - Seg1, Seg2 and anode SHALL all be registered and change on the same edge.
REQ-024 led = 0x00 in OFF, 0x01 in MENU, mode_led of the selected mode in ACTIVE; registered.

Reset
REQ-025 On reset assertion SHALL asynchronously set: state OFF, mode_sel = 1, digit = 0, anode = 0x01, Seg1 = Seg2 = led = 0x00, all counters and debouncers cleared to the released level.
REQ-026 Reset asserted mid-operation SHALL abandon the operation; a button held through reset deassertion SHALL produce a press pulse only after DEBOUNCE_CYCLES.

Configuration
REQ-027 With MODE_CTRL_AUTO_OFF_EN defined: an idle counter SHALL clear on any press pulse and on mode_busy != 0; in MENU or ACTIVE, reaching IDLE_CYCLES SHALL force OFF. Without the macro there SHALL be no idle counter and no auto-off.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=50, SCAN_DIV=3, IDLE_CYCLES=200)
REQ-028 Power press held 10 cycles -> power_on=1, mode_sel=0001; during digit 0 Seg1=60; all other digits 00.
REQ-029 Four select presses in MENU -> mode_sel 0010, 0100, 1000, 0001; 2-cycle select glitch -> no change.
REQ-030 confirm with mode_sel=0100, mode_seg digit5=0xB6 -> mode_entered=1; Seg2=B6 while anode=0x20; exit with mode_busy[2]=1 -> stays ACTIVE; exit after busy clears -> MENU.
REQ-031 Power held 60 cycles in ACTIVE -> OFF, all outputs blank; keep holding -> stays OFF until release and re-press.
REQ-032 Reset pulse mid-scan with anode=0x10 -> same cycle anode=0x01, Seg1=Seg2=led=00, state OFF.
REQ-033 With MODE_CTRL_AUTO_OFF_EN, MENU idle for 200 cycles -> power_on=0; without it -> power_on stays 1.
